// File: rtl/weight_wr_ctrl_if.sv
// Weight write controller bus: job request, byte stream in, array write port
// and sparsity/status out. master = job/data source, slave = controller.
interface weight_wr_ctrl_if #(
  parameter int COL_W = 8
);
  logic             start;
  logic [COL_W-1:0] col_num;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             wr_en;
  logic [COL_W+2:0] wr_addr;
  logic [8:0]       wr_data;
  logic [7:0]       sp_mask;
  logic             mask_valid;
  logic [COL_W+3:0] sp_total;
  logic             busy;
  logic             done;

  modport master (
    output start, col_num, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, sp_mask, mask_valid,
           sp_total, busy, done
  );

  modport slave (
    input  start, col_num, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, sp_mask, mask_valid,
           sp_total, busy, done
  );
endinterface

// File: rtl/weight_wr_ctrl.sv
// Weight write controller: collects 8 weight bytes per column, tags zero
// bytes as sparse, then writes the column into the weight array.
// Optional feature macro: WEIGHT_SKIP_ZERO_EN -- when defined, zero bytes are
// skipped during WRITE (an all-zero column takes one idle WRITE cycle).
module weight_wr_ctrl #(
  parameter int COL_W = 8
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            sys_en,
  weight_wr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [COL_W-1:0]  col_num_q, col_num_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [7:0][7:0]   wbuf_q, wbuf_d;
  logic [7:0]        mask_q, mask_d;
  logic [7:0]        sp_mask_q, sp_mask_d;
  logic [COL_W+3:0]  sp_total_q, sp_total_d;
  logic              mask_valid_q, mask_valid_d;
  logic              zero_byte;
  logic              last_byte;
  logic              in_write;
  logic [7:0]        cur_byte;

`ifdef WEIGHT_SKIP_ZERO_EN
  logic [3:0]        nxt;

  // First nonzero byte index at or above 'from'; 8 means none left
  function automatic logic [3:0] next_nz(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      if (4'(k) >= from && !m[k]) r = 4'(k);
    end
    return r;
  endfunction
`endif

  // Next-state logic; with sys_en low every register keeps its value
  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    col_num_d    = col_num_q;
    byte_idx_d   = byte_idx_q;
    wbuf_d       = wbuf_q;
    mask_d       = mask_q;
    sp_mask_d    = sp_mask_q;
    sp_total_d   = sp_total_q;
    mask_valid_d = mask_valid_q;
    zero_byte    = (bus.in_data == 8'd0);
    last_byte    = 1'b0;
`ifdef WEIGHT_SKIP_ZERO_EN
    nxt          = 4'd0;
`endif
    if (sys_en) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            col_idx_d  = '0;
            byte_idx_d = 3'd0;
            sp_total_d = '0;
            sp_mask_d  = 8'd0;
            col_num_d  = bus.col_num;
            state_d    = (bus.col_num == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            wbuf_d[byte_idx_q] = bus.in_data;
            mask_d[byte_idx_q] = zero_byte;
            sp_total_d         = sp_total_q + (COL_W+4)'(zero_byte);
            if (byte_idx_q == 3'd7) begin
              state_d      = WRITE;
              sp_mask_d    = mask_d;
              mask_valid_d = 1'b1;
`ifdef WEIGHT_SKIP_ZERO_EN
              nxt          = next_nz(mask_d, 4'd0);
              byte_idx_d   = nxt[2:0];
`else
              byte_idx_d   = 3'd0;
`endif
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
            end
          end
        end
        WRITE: begin
          mask_valid_d = 1'b0;
`ifdef WEIGHT_SKIP_ZERO_EN
          nxt       = next_nz(mask_q, {1'b0, byte_idx_q} + 4'd1);
          last_byte = nxt[3];
`else
          last_byte = (byte_idx_q == 3'd7);
`endif
          if (last_byte) begin
            if (col_idx_q == col_num_q - COL_W'(1)) begin
              state_d = DONE;
            end else begin
              col_idx_d  = col_idx_q + COL_W'(1);
              byte_idx_d = 3'd0;
              state_d    = LOAD;
            end
          end else begin
`ifdef WEIGHT_SKIP_ZERO_EN
            byte_idx_d = nxt[2:0];
`else
            byte_idx_d = byte_idx_q + 3'd1;
`endif
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers, cleared asynchronously so a reset aborts any job
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_idx_q    <= '0;
      col_num_q    <= '0;
      byte_idx_q   <= 3'd0;
      wbuf_q       <= '0;
      mask_q       <= 8'd0;
      sp_mask_q    <= 8'd0;
      sp_total_q   <= '0;
      mask_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      col_num_q    <= col_num_d;
      byte_idx_q   <= byte_idx_d;
      wbuf_q       <= wbuf_d;
      mask_q       <= mask_d;
      sp_mask_q    <= sp_mask_d;
      sp_total_q   <= sp_total_d;
      mask_valid_q <= mask_valid_q ? mask_valid_d : mask_valid_d;
    end
  end

  // Outputs decoded from registered state; strobes are squashed while disabled
  always_comb begin
    in_write = (state_q == WRITE);
    cur_byte = wbuf_q[byte_idx_q];
    bus.in_ready   = sys_en && (state_q == LOAD);
`ifdef WEIGHT_SKIP_ZERO_EN
    bus.wr_en      = sys_en && in_write && !mask_q[byte_idx_q];
`else
    bus.wr_en      = sys_en && in_write;
`endif
    bus.wr_addr    = in_write ? {col_idx_q, byte_idx_q} : '0;
    bus.wr_data    = in_write ? {(cur_byte == 8'd0), cur_byte} : 9'd0;
    bus.sp_mask    = sp_mask_q;
    bus.mask_valid = sys_en && mask_valid_q;
    bus.sp_total   = sp_total_q;
    bus.busy       = (state_q != IDLE);
    bus.done       = sys_en && (state_q == DONE);
  end

endmodule
